// File: rtl/mul_lopd_pkg.sv
// Shared types and constants for the pipelined leading-one position detector.
// Chunk width is fixed at 8 bits; wider operands are built from several chunks.
package mul_lopd_pkg;

  localparam int LOPD_CHUNK_W = 8;

  function automatic int lopd_pos_w(input int width);
    return $clog2(width);
  endfunction

  typedef struct packed {
    logic [2:0] pos;
    logic       zero;
  } lopd_chunk_t;

endpackage

// File: rtl/mul_lopd_chunk8.sv
// Combinational 8-bit leading-one detector: leading-zero count from bit 7 plus an all-zero flag.
module mul_lopd_chunk8
  import mul_lopd_pkg::*;
(
  input  logic [7:0]  i_data,
  output lopd_chunk_t o_chunk
);

  // Ascending scan so the highest set bit is the last one written and wins.
  always_comb begin
    o_chunk.pos  = 3'd0;
    o_chunk.zero = (i_data == 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (i_data[i]) begin
        o_chunk.pos = 3'(7 - i);
      end
    end
  end

endmodule

// File: rtl/mul_lopd_pipe.sv
// Two-stage pipelined leading-one position detector with valid/ready handshake.
// Define MUL_LOPD_NORM_EN to add o_norm_data, the operand shifted so its leading one sits at the MSB.
module mul_lopd_pipe
  import mul_lopd_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int POS_W  = lopd_pos_w(WIDTH),
  localparam int NCHUNK = WIDTH / LOPD_CHUNK_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [POS_W-1:0] o_pos_one,
`ifdef MUL_LOPD_NORM_EN
  output logic             o_zero_flag,
  output logic [WIDTH-1:0] o_norm_data
`else
  output logic             o_zero_flag
`endif
);

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("mul_lopd_pipe: WIDTH must be a power of two between 8 and 64");
  end

  lopd_chunk_t      chunk_c  [NCHUNK];
  lopd_chunk_t      s1_chunk [NCHUNK];
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [POS_W-1:0] pos_c;
  logic             zero_c;
  logic [POS_W-1:0] s2_pos;
  logic             s2_zero;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    mul_lopd_chunk8 u_chunk (
      .i_data  (i_data[k*LOPD_CHUNK_W +: LOPD_CHUNK_W]),
      .o_chunk (chunk_c[k])
    );
  end

  assign s2_adv  = !s2_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = !s2_valid || i_ready || !s1_valid;

  // Chunk results are plain data; only the valid bit needs a reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (s1_adv && i_valid) begin
      s1_chunk <= chunk_c;
    end
  end

  // Most significant non-zero chunk wins; higher k is scanned last so it overrides.
  always_comb begin
    pos_c  = '0;
    zero_c = 1'b1;
    for (int k = 0; k < NCHUNK; k++) begin
      if (!s1_chunk[k].zero) begin
        pos_c  = POS_W'((NCHUNK - 1 - k) * LOPD_CHUNK_W) + POS_W'(s1_chunk[k].pos);
        zero_c = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_pos   <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pos  <= pos_c;
        s2_zero <= zero_c;
      end
    end
  end

  assign o_valid     = s2_valid;
  assign o_pos_one   = s2_pos;
  assign o_zero_flag = s2_zero;

`ifdef MUL_LOPD_NORM_EN
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s2_norm;

  always_ff @(posedge i_clk) begin
    if (s1_adv && i_valid) begin
      s1_data <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_norm <= '0;
    end else if (s2_adv && s1_valid) begin
      s2_norm <= zero_c ? '0 : (s1_data << pos_c);
    end
  end

  assign o_norm_data = s2_norm;
`endif

endmodule

// File: tb/tb_mul_lopd_pipe.sv
// Self-checking bench for mul_lopd_pipe at WIDTH 16, 32 and 64; honours MUL_LOPD_NORM_EN.
// Expected results are queued when an input transfer happens and compared when a result transfers out.
module tb_mul_lopd_pipe;

  typedef struct {
    int          pos;
    bit          zero;
    logic [63:0] norm;
  } exp_t;

  typedef struct {
    int          sel;
    logic [63:0] data;
    int          pos;
    bit          zero;
    logic [63:0] norm;
    bit          b2b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        val16, val32, val64;
  logic        or16, or32, or64;
  logic        v16, v32, v64;
  logic        rdy16, rdy32, rdy64;
  logic [15:0] d16;
  logic [31:0] d32;
  logic [63:0] d64;
  logic [3:0]  pos16;
  logic [4:0]  pos32;
  logic [5:0]  pos64;
  logic        z16, z32, z64;
`ifdef MUL_LOPD_NORM_EN
  logic [15:0] n16;
  logic [31:0] n32;
  logic [63:0] n64;
`endif

  exp_t q16[$];
  exp_t q32[$];
  exp_t q64[$];
  exp_t e16, e32, e64;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  mul_lopd_pipe #(.WIDTH(16)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(val16), .o_ready(or16), .i_data(d16),
    .o_valid(v16), .i_ready(rdy16), .o_pos_one(pos16), .o_zero_flag(z16)
`ifdef MUL_LOPD_NORM_EN
    , .o_norm_data(n16)
`endif
  );

  mul_lopd_pipe #(.WIDTH(32)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(val32), .o_ready(or32), .i_data(d32),
    .o_valid(v32), .i_ready(rdy32), .o_pos_one(pos32), .o_zero_flag(z32)
`ifdef MUL_LOPD_NORM_EN
    , .o_norm_data(n32)
`endif
  );

  mul_lopd_pipe #(.WIDTH(64)) u64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(val64), .o_ready(or64), .i_data(d64),
    .o_valid(v64), .i_ready(rdy64), .o_pos_one(pos64), .o_zero_flag(z64)
`ifdef MUL_LOPD_NORM_EN
    , .o_norm_data(n64)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // Bit-level reference, independent of the chunked structure of the design.
  function automatic exp_t lopd_model(input logic [63:0] d, input int w);
    exp_t r;
    r.pos  = 0;
    r.zero = 1'b1;
    r.norm = '0;
    for (int i = 0; i < w; i++) begin
      if (d[i]) begin
        r.pos  = w - 1 - i;
        r.zero = 1'b0;
      end
    end
    if (!r.zero) begin
      r.norm = d << r.pos;
      if (w < 64) r.norm = r.norm & ((64'd1 << w) - 64'd1);
    end
    return r;
  endfunction

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return or16;
      1:       return or32;
      default: return or64;
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [63:0] data);
    case (sel)
      0:       begin val16 = v; d16 = data[15:0]; end
      1:       begin val32 = v; d32 = data[31:0]; end
      default: begin val64 = v; d64 = data;       end
    endcase
  endtask

  // Holds valid until the block accepts, queueing the expected result at the accepting edge.
  task automatic applyStimulus(input int sel, input logic [63:0] data, input exp_t exp, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    drive(sel, 1'b1, data);
    while (!done && waits < 200) begin
      @(negedge clk);
      if (ready_of(sel)) begin
        case (sel)
          0:       q16.push_back(exp);
          1:       q32.push_back(exp);
          default: q64.push_back(exp);
        endcase
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) checkOutput("accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, data);
  endtask

  always @(negedge clk) begin
    if (rst_n && v16 && rdy16) begin
      if (q16.size() == 0) checkOutput("w16 unexpected result", 64'd1, 64'd0);
      else begin
        e16 = q16.pop_front();
        checkOutput("w16 pos", 64'(pos16), 64'(e16.pos));
        checkOutput("w16 zero", 64'(z16), 64'(e16.zero));
`ifdef MUL_LOPD_NORM_EN
        checkOutput("w16 norm", 64'(n16), e16.norm);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v32 && rdy32) begin
      if (q32.size() == 0) checkOutput("w32 unexpected result", 64'd1, 64'd0);
      else begin
        e32 = q32.pop_front();
        checkOutput("w32 pos", 64'(pos32), 64'(e32.pos));
        checkOutput("w32 zero", 64'(z32), 64'(e32.zero));
`ifdef MUL_LOPD_NORM_EN
        checkOutput("w32 norm", 64'(n32), e32.norm);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v64 && rdy64) begin
      if (q64.size() == 0) checkOutput("w64 unexpected result", 64'd1, 64'd0);
      else begin
        e64 = q64.pop_front();
        checkOutput("w64 pos", 64'(pos64), 64'(e64.pos));
        checkOutput("w64 zero", 64'(z64), 64'(e64.zero));
`ifdef MUL_LOPD_NORM_EN
        checkOutput("w64 norm", n64, e64.norm);
`endif
      end
    end
  end

  initial begin
    vec_t tbl [10];
    exp_t e;
    int   w;
    logic [63:0] rd;

    tbl[0] = '{0, 64'h8000,                0,  1'b0, 64'h8000,                1'b1};
    tbl[1] = '{0, 64'h0000,                0,  1'b1, 64'h0,                   1'b1};
    tbl[2] = '{0, 64'h00F0,                8,  1'b0, 64'hF000,                1'b1};
    tbl[3] = '{0, 64'h0100,                7,  1'b0, 64'h8000,                1'b1};
    tbl[4] = '{1, 64'h0000_1234,           19, 1'b0, 64'h91A0_0000,           1'b0};
    tbl[5] = '{1, 64'hFFFF_FFFF,           0,  1'b0, 64'hFFFF_FFFF,           1'b0};
    tbl[6] = '{1, 64'h0,                   0,  1'b1, 64'h0,                   1'b0};
    tbl[7] = '{2, 64'h1,                   63, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    tbl[8] = '{2, 64'h0000_0001_0000_0000, 31, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    tbl[9] = '{0, 64'hFFFF,                0,  1'b0, 64'hFFFF,                1'b0};

    rst_n = 1'b0;
    val16 = 1'b0; val32 = 1'b0; val64 = 1'b0;
    rdy16 = 1'b1; rdy32 = 1'b1; rdy64 = 1'b1;
    d16 = '0; d32 = '0; d64 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset o_valid", 64'(v16), 64'd0);
    checkOutput("reset o_pos_one", 64'(pos16), 64'd0);
    checkOutput("reset o_zero_flag", 64'(z16), 64'd0);
    checkOutput("reset o_ready", 64'(or16), 64'd1);
`ifdef MUL_LOPD_NORM_EN
    checkOutput("reset o_norm_data", 64'(n16), 64'd0);
`endif

    // Single transfer: result must appear exactly two edges after acceptance.
    e = '{15, 1'b0, 64'h8000};
    applyStimulus(0, 64'h0001, e, w);
    checkOutput("latency cycle1 o_valid", 64'(v16), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("latency cycle2 o_valid", 64'(v16), 64'd1);

    for (int i = 0; i < 10; i++) begin
      e = '{tbl[i].pos, tbl[i].zero, tbl[i].norm};
      applyStimulus(tbl[i].sel, tbl[i].data, e, w);
      if (tbl[i].b2b) checkOutput("back-to-back accept waits", 64'(w), 64'd0);
    end

    // Backpressure: two items fill s1/s2, then o_ready must drop and s2 must hold.
    repeat (4) @(posedge clk);
    #1;
    rdy16 = 1'b0;
    applyStimulus(0, 64'h0001, lopd_model(64'h0001, 16), w);
    applyStimulus(0, 64'h0400, lopd_model(64'h0400, 16), w);
    checkOutput("stall o_ready", 64'(or16), 64'd0);
    checkOutput("stall o_valid", 64'(v16), 64'd1);
    fork
      begin
        applyStimulus(0, 64'h0030, lopd_model(64'h0030, 16), w);
        applyStimulus(0, 64'h0000, lopd_model(64'h0000, 16), w);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall o_pos_one", 64'(pos16), 64'd15);
          checkOutput("stall hold o_valid", 64'(v16), 64'd1);
        end
        @(posedge clk);
        #1;
        rdy16 = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Reset while both stages are full: in-flight results are discarded.
    rdy16 = 1'b0;
    applyStimulus(0, 64'h0002, lopd_model(64'h0002, 16), w);
    applyStimulus(0, 64'h0000, lopd_model(64'h0000, 16), w);
    rst_n = 1'b0;
    q16.delete();
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("mid reset o_valid", 64'(v16), 64'd0);
    checkOutput("mid reset o_pos_one", 64'(pos16), 64'd0);
    checkOutput("mid reset o_zero_flag", 64'(z16), 64'd0);
    checkOutput("mid reset o_ready", 64'(or16), 64'd1);
    rdy16 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("no stale result", 64'(v16), 64'd0);
    end
    @(posedge clk);
    #1;

    for (int b = 63; b >= 0; b--) begin
      e = '{63 - b, 1'b0, 64'h8000_0000_0000_0000};
      applyStimulus(2, 64'd1 << b, e, w);
    end
    e = '{0, 1'b1, 64'h0};
    applyStimulus(2, 64'h0, e, w);

    for (int i = 0; i < 20; i++) begin
      rd = 64'($urandom() >> $urandom_range(0, 31));
      applyStimulus(1, rd, lopd_model(rd, 32), w);
    end

    repeat (10) @(posedge clk);
    #1;
    checkOutput("w16 queue drained", 64'(q16.size()), 64'd0);
    checkOutput("w32 queue drained", 64'(q32.size()), 64'd0);
    checkOutput("w64 queue drained", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
